// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters
module alu_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Flush,
  input  logic                      Req0Valid,
  input  logic                      Req1Valid,
  output logic                      Req0Ready,
  output logic                      Req1Ready,
  input  logic [DATA_WIDTH-1:0]     Req0SrcA,
  input  logic [DATA_WIDTH-1:0]     Req0SrcB,
  input  logic [DATA_WIDTH-1:0]     Req1SrcA,
  input  logic [DATA_WIDTH-1:0]     Req1SrcB,
  input  logic [ALU_CTRL_WIDTH-1:0] Req0Ctrl,
  input  logic [ALU_CTRL_WIDTH-1:0] Req1Ctrl,
  input  logic [DATA_WIDTH-1:0]     Req0PC,
  input  logic [DATA_WIDTH-1:0]     Req1PC,
  output logic [DATA_WIDTH-1:0]     AluSrcA,
  output logic [DATA_WIDTH-1:0]     AluSrcB,
  output logic [DATA_WIDTH-1:0]     AluPC,
  output logic [ALU_CTRL_WIDTH-1:0] AluControl,
  input  logic [DATA_WIDTH-1:0]     AluResult,
  input  logic                      AluZero,
  output logic                      RspValid,
  input  logic                      RspReady,
  output logic                      RspId,
  output logic [DATA_WIDTH-1:0]     RspResult,
  output logic                      RspZero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d, pend_id_q, pend_id_d, rsp_id_q, rsp_id_d, rsp_zero_q, rsp_zero_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, pc_q, pc_d, res_q, res_d;
  logic [ALU_CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic can_accept, win, accept, cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      pend_id_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_zero_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      pc_q       <= '0;
      ctrl_q     <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      pend_id_q  <= pend_id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_zero_q <= rsp_zero_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pc_q       <= pc_d;
      ctrl_q     <= ctrl_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    state_d = Flush ? IDLE :
              accept ? EXEC :
              state_q == EXEC ? RESP :
              (state_q == RESP && RspReady) ? IDLE : state_q;
    prio_d    = accept ? !win : prio_q;
    pend_id_d = accept ? win : pend_id_q;
    a_d       = accept ? (win ? Req1SrcA : Req0SrcA) : a_q;
    b_d       = accept ? (win ? Req1SrcB : Req0SrcB) : b_q;
    pc_d      = accept ? (win ? Req1PC : Req0PC) : pc_q;
    ctrl_d    = accept ? (win ? Req1Ctrl : Req0Ctrl) : ctrl_q;
    cap        = state_q == EXEC && !Flush;
    res_d      = cap ? AluResult : res_q;
    rsp_zero_d = cap ? AluZero : rsp_zero_q;
    rsp_id_d   = cap ? pend_id_q : rsp_id_q;
  end

  // Ready is gated by rst so requesters never see a handshake during reset.
  always_comb begin
    can_accept = !rst && !Flush && (state_q == IDLE || (state_q == RESP && RspReady));
    win        = (Req0Valid && Req1Valid) ? prio_q : Req1Valid;
    Req0Ready  = can_accept && Req0Valid && !win;
    Req1Ready  = can_accept && Req1Valid && win;
    accept     = Req0Ready || Req1Ready;
    AluSrcA    = a_q;
    AluSrcB    = b_q;
    AluPC      = pc_q;
    AluControl = ctrl_q;
    RspValid   = state_q == RESP;
    RspId      = rsp_id_q;
    RspResult  = res_q;
    RspZero    = rsp_zero_q;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of the ALU arbiter against a small ALU model
module tb_alu_arbiter;
  logic clk = 0, rst, Flush, Req0Valid, Req1Valid, Req0Ready, Req1Ready;
  logic [31:0] Req0SrcA, Req0SrcB, Req1SrcA, Req1SrcB, Req0PC, Req1PC;
  logic [3:0] Req0Ctrl, Req1Ctrl, AluControl;
  logic [31:0] AluSrcA, AluSrcB, AluPC, AluResult, RspResult;
  logic AluZero, RspValid, RspReady, RspId, RspZero;
  int n_cmp = 0, n_err = 0, g0 = 0, g1 = 0;

  always #5 clk = ~clk;

  // add / sub / xor are the only codes the stimulus uses
  always_comb begin
    AluResult = AluControl == 4'b0000 ? AluSrcA + AluSrcB :
                AluControl == 4'b0001 ? AluSrcA - AluSrcB :
                AluControl == 4'b0101 ? AluSrcA ^ AluSrcB : 32'h0;
    AluZero   = AluResult == 32'h0;
  end

  alu_arbiter dut (
    .clk(clk), .rst(rst), .Flush(Flush),
    .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
    .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
    .Req0SrcA(Req0SrcA), .Req0SrcB(Req0SrcB), .Req1SrcA(Req1SrcA), .Req1SrcB(Req1SrcB),
    .Req0Ctrl(Req0Ctrl), .Req1Ctrl(Req1Ctrl), .Req0PC(Req0PC), .Req1PC(Req1PC),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluPC(AluPC), .AluControl(AluControl),
    .AluResult(AluResult), .AluZero(AluZero),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
    .RspResult(RspResult), .RspZero(RspZero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    Req0Valid = v; Req0SrcA = a; Req0SrcB = b; Req0Ctrl = c;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    Req1Valid = v; Req1SrcA = a; Req1SrcB = b; Req1Ctrl = c;
  endtask

  initial begin
    rst = 1; Flush = 0; RspReady = 1; Req0PC = 32'h100; Req1PC = 32'h200;
    set0(1, 5, 7, 4'b0000);
    set1(0, 0, 0, 4'b0000);
    tick; tick;
    chk("rst_ready0", Req0Ready, 0);
    chk("rst_rspvalid", RspValid, 0);
    chk("rst_rspid", RspId, 0);
    chk("rst_result", RspResult, 0);
    chk("rst_zero", RspZero, 0);
    chk("rst_alua", AluSrcA, 0);
    chk("rst_aluctrl", AluControl, 0);
    // single request
    rst = 0; #1;
    chk("single_ready", Req0Ready, 1);
    tick; Req0Valid = 0; #1;
    chk("single_alua", AluSrcA, 5);
    chk("single_alub", AluSrcB, 7);
    chk("single_alupc", AluPC, 32'h100);
    chk("single_exec_valid", RspValid, 0);
    tick; #1;
    chk("single_valid", RspValid, 1);
    chk("single_id", RspId, 0);
    chk("single_result", RspResult, 12);
    chk("single_zero", RspZero, 0);
    tick; #1;
    chk("single_done", RspValid, 0);
    // contention and fairness: grants alternate starting with Req0
    rst = 1; tick; rst = 0;
    set0(1, 3, 3, 4'b0001);
    set1(1, 32'hF0, 32'h0F, 4'b0101);
    for (int cyc = 1; cyc <= 17; cyc++) begin
      if (cyc == 16) begin Req0Valid = 0; Req1Valid = 0; end
      #1;
      if (cyc % 2 == 1 && cyc <= 15) begin
        chk("fair_ready0", Req0Ready, ((cyc - 1) / 2) % 2 == 0);
        chk("fair_ready1", Req1Ready, ((cyc - 1) / 2) % 2 == 1);
        g0 += int'(Req0Ready);
        g1 += int'(Req1Ready);
      end
      if (cyc % 2 == 1 && cyc >= 3) begin
        chk("fair_valid", RspValid, 1);
        chk("fair_id", RspId, ((cyc - 3) / 2) % 2);
        chk("fair_result", RspResult, ((cyc - 3) / 2) % 2 == 1 ? 32'hFF : 32'h0);
        chk("fair_zero", RspZero, ((cyc - 3) / 2) % 2 == 0);
      end
      if (cyc % 2 == 0) chk("fair_exec_valid", RspValid, 0);
      tick;
    end
    chk("fair_grants0", g0, 4);
    chk("fair_grants1", g1, 4);
    // backpressure
    rst = 1; tick; rst = 0;
    set0(1, 10, 20, 4'b0000);
    set1(1, 1, 2, 4'b0000);
    #1;
    chk("bp_ready0", Req0Ready, 1);
    chk("bp_ready1_c1", Req1Ready, 0);
    tick; Req0Valid = 0; #1;
    chk("bp_exec_ready1", Req1Ready, 0);
    tick; RspReady = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_valid", RspValid, 1);
      chk("bp_result", RspResult, 30);
      chk("bp_id", RspId, 0);
      chk("bp_ready1", Req1Ready, 0);
      tick;
    end
    RspReady = 1; #1;
    chk("bp_release_ready1", Req1Ready, 1);
    tick; Req1Valid = 0;
    tick; #1;
    chk("bp_r1_valid", RspValid, 1);
    chk("bp_r1_result", RspResult, 3);
    chk("bp_r1_id", RspId, 1);
    tick; #1;
    chk("bp_idle", RspValid, 0);
    // flush in EXEC, then a fresh request, then flush in RESP
    set0(1, 100, 23, 4'b0000); #1;
    chk("fl_ready0", Req0Ready, 1);
    tick; Req0Valid = 0; Flush = 1;
    tick; Flush = 0; set1(1, 7, 8, 4'b0000); #1;
    chk("fl_valid_a", RspValid, 0);
    chk("fl_new_ready1", Req1Ready, 1);
    tick; Req1Valid = 0; #1;
    chk("fl_valid_b", RspValid, 0);
    tick; #1;
    chk("fl_new_valid", RspValid, 1);
    chk("fl_new_result", RspResult, 15);
    chk("fl_new_id", RspId, 1);
    Flush = 1; Req0Valid = 1; #1;
    chk("fl_no_accept", Req0Ready, 0);
    tick; Flush = 0; Req0Valid = 0; #1;
    chk("fl_discard", RspValid, 0);
    // reset while a response is pending
    set0(1, 6, 3, 4'b0101); RspReady = 0; #1;
    chk("mr_ready0", Req0Ready, 1);
    tick; Req0Valid = 0;
    tick; #1;
    chk("mr_valid", RspValid, 1);
    chk("mr_result", RspResult, 5);
    chk("mr_ctrl", AluControl, 4'b0101);
    rst = 1;
    tick; rst = 0; set0(1, 1, 1, 4'b0000); set1(1, 2, 2, 4'b0000); RspReady = 1; #1;
    chk("mr_rst_valid", RspValid, 0);
    chk("mr_rst_result", RspResult, 0);
    chk("mr_rst_ctrl", AluControl, 0);
    chk("mr_rst_alua", AluSrcA, 0);
    chk("mr_prio_ready0", Req0Ready, 1);
    chk("mr_prio_ready1", Req1Ready, 0);
    tick; Req0Valid = 0; Req1Valid = 0;
    tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
